// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Bundles the fetch stage's memory port, decode-side control and IF/ID outputs.
//   master : fetch_unit side. Drives mem_addr and if_*; receives mem_rdata,
//            stall, redirect_valid and redirect_pc.
//   slave  : memory/decode side. This is the mirror image of master.
interface fetch_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [DATA_W-1:0] if_instr;
    logic [DATA_W-1:0] if_imm;
    logic [ADDR_W-1:0] if_pc;
    logic              if_valid;

    modport master (
        output mem_addr, if_instr, if_imm, if_pc, if_valid,
        input  mem_rdata, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_addr, if_instr, if_imm, if_pc, if_valid,
        output mem_rdata, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. After reset it reads the two-word reset vector at
// M[0] and M[1]. It then fetches 1- and 2-word instructions in sequence and
// presents them in the IF/ID register. Bit 0 of the opcode word selects the
// length: 1 means a 2-word instruction.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master. It carries the memory address and read data
//          (the read is asynchronous), stall, redirect_valid, redirect_pc and
//          the IF/ID outputs if_instr, if_imm, if_pc and if_valid.
//
// state   | meaning
// --------+---------------------------------------------------------------
// BOOT_LO | reading M[0], the low 16 bits of the reset vector
// BOOT_HI | reading M[1], the upper bits of the reset vector
// FETCH   | reading an opcode word
// IMM     | reading the immediate word of a 2-word instruction
module fetch_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {BOOT_LO, BOOT_HI, FETCH, IMM} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [15:0]       vec_lo, vec_lo_n;
    logic [DATA_W-1:0] held, held_n;
    logic [DATA_W-1:0] instr_q, instr_n;
    logic [DATA_W-1:0] imm_q, imm_n;
    logic [ADDR_W-1:0] ipc_q, ipc_n;
    logic              valid_q, valid_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BOOT_LO;
            pc      <= '0;
            vec_lo  <= '0;
            held    <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            vec_lo  <= vec_lo_n;
            held    <= held_n;
            instr_q <= instr_n;
            imm_q   <= imm_n;
            ipc_q   <= ipc_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        vec_lo_n = vec_lo;
        held_n   = held;
        instr_n  = instr_q;
        imm_n    = imm_q;
        ipc_n    = ipc_q;
        valid_n  = valid_q;

        case (state)
            BOOT_LO: begin
                vec_lo_n = bus.mem_rdata[15:0];
                pc_n     = ADDR_W'(1);
                state_n  = BOOT_HI;
            end
            BOOT_HI: begin
                // Only the bits that fit in the PC are taken from M[1].
                pc_n    = {bus.mem_rdata[ADDR_W-17:0], vec_lo};
                state_n = FETCH;
            end
            FETCH: begin
                if (bus.redirect_valid) begin
                    pc_n    = bus.redirect_pc;
                    valid_n = 1'b0;
                end else if (!bus.stall) begin
                    pc_n = pc + ADDR_W'(1);
                    if (bus.mem_rdata[0]) begin
                        held_n  = bus.mem_rdata;
                        valid_n = 1'b0;
                        state_n = IMM;
                    end else begin
                        instr_n = bus.mem_rdata;
                        imm_n   = '0;
                        ipc_n   = pc;
                        valid_n = 1'b1;
                    end
                end
            end
            IMM: begin
                if (bus.redirect_valid) begin
                    pc_n    = bus.redirect_pc;
                    valid_n = 1'b0;
                    held_n  = '0;
                    state_n = FETCH;
                end else if (!bus.stall) begin
                    instr_n = held;
                    imm_n   = bus.mem_rdata;
                    // The opcode was one word back. This wraps to the top
                    // address when the immediate comes from address 0.
                    ipc_n   = pc - ADDR_W'(1);
                    valid_n = 1'b1;
                    pc_n    = pc + ADDR_W'(1);
                    state_n = FETCH;
                end
            end
            default: state_n = BOOT_LO;
        endcase
    end

    assign bus.mem_addr = pc;
    assign bus.if_instr = instr_q;
    assign bus.if_imm   = imm_q;
    assign bus.if_pc    = ipc_q;
    assign bus.if_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.DATA_W(16), .ADDR_W(20)) bus ();

    fetch_unit #(.DATA_W(16), .ADDR_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [logic [19:0]];
    int checks = 0;
    int passes = 0;

    function automatic logic [15:0] rd(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    // Asynchronous-read memory. It is refreshed on both clock edges so that
    // contents written by the bench are picked up.
    always @(bus.mem_addr or clk) bus.mem_rdata = rd(bus.mem_addr);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [19:0] vec);
        mem[20'h0] = vec[15:0];
        mem[20'h1] = {12'hABC, vec[19:16]};
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        mem.delete();
        mem[20'h0] = 16'h0010;
        mem[20'h1] = 16'h0000;
        mem[20'h10] = 16'h1234;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        rst = 1'b1;
        tick(); tick();
        checks++; if ({bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid} !== 53'h0) $display("FAIL reset_outputs: got %h want 0", {bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid}); else passes++;
        checks++; if (bus.mem_addr !== 20'h0) $display("FAIL reset_addr: got %h want 0", bus.mem_addr); else passes++;
        // Stall and redirect are driven during boot. The boot states ignore both.
        rst = 1'b0; bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 20'h55;
        tick();
        checks++; if (bus.mem_addr !== 20'h1) $display("FAIL boot_addr1: got %h want 1", bus.mem_addr); else passes++;
        checks++; if (bus.if_valid !== 1'b0) $display("FAIL boot_valid1: got %b want 0", bus.if_valid); else passes++;
        tick();
        checks++; if (bus.mem_addr !== 20'h10) $display("FAIL boot_addr2: got %h want 10", bus.mem_addr); else passes++;
        checks++; if (bus.if_valid !== 1'b0) $display("FAIL boot_valid2: got %b want 0", bus.if_valid); else passes++;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0;
        tick();
        checks++; if ({bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid} !== {16'h1234, 16'h0, 20'h10, 1'b1}) $display("FAIL first_issue: got %h/%h/%h/%b want 1234/0000/00010/1", bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid); else passes++;
    endtask

    // Covers the two-word sequence, then stalls in both FETCH and IMM.
    task automatic test_two_word_and_stall;
        mem.delete();
        mem[20'h10] = 16'h2001; mem[20'h11] = 16'hBEEF; mem[20'h12] = 16'h0002;
        mem[20'h13] = 16'h0000; mem[20'h14] = 16'h3003; mem[20'h15] = 16'h5555;
        do_reset(20'h10);
        tick();
        checks++; if (bus.if_valid !== 1'b0 || bus.mem_addr !== 20'h11) $display("FAIL two_word_bubble: got valid %b addr %h want 0 / 11", bus.if_valid, bus.mem_addr); else passes++;
        tick();
        checks++; if ({bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid} !== {16'h2001, 16'hBEEF, 20'h10, 1'b1}) $display("FAIL two_word_issue: got %h/%h/%h/%b want 2001/beef/00010/1", bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid); else passes++;
        tick();
        checks++; if ({bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid} !== {16'h0002, 16'h0, 20'h12, 1'b1}) $display("FAIL after_two_word: got %h/%h/%h/%b want 0002/0000/00012/1", bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid); else passes++;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid, bus.mem_addr} !== {16'h0002, 16'h0, 20'h12, 1'b1, 20'h13}) $display("FAIL stall_fetch_%0d: got %h/%h/%h/%b addr %h want 0002/0000/00012/1 addr 13", i, bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid, bus.mem_addr); else passes++;
        end
        bus.stall = 1'b0;
        tick();
        checks++; if ({bus.if_instr, bus.if_pc, bus.if_valid} !== {16'h0000, 20'h13, 1'b1}) $display("FAIL stall_resume: got %h/%h/%b want 0000/00013/1", bus.if_instr, bus.if_pc, bus.if_valid); else passes++;
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.if_valid !== 1'b0 || bus.mem_addr !== 20'h15) $display("FAIL stall_imm_%0d: got valid %b addr %h want 0 / 15", i, bus.if_valid, bus.mem_addr); else passes++;
        end
        bus.stall = 1'b0;
        tick();
        checks++; if ({bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid} !== {16'h3003, 16'h5555, 20'h14, 1'b1}) $display("FAIL stall_imm_resume: got %h/%h/%h/%b want 3003/5555/00014/1", bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid); else passes++;
    endtask

    task automatic test_redirect;
        mem.delete();
        mem[20'h10] = 16'h2001; mem[20'h11] = 16'hBEEF; mem[20'h40] = 16'h0040;
        do_reset(20'h10);
        tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 20'h40; bus.stall = 1'b1;
        tick();
        bus.redirect_valid = 1'b0; bus.stall = 1'b0;
        checks++; if (bus.if_valid !== 1'b0 || bus.mem_addr !== 20'h40) $display("FAIL redirect_bubble: got valid %b addr %h want 0 / 40", bus.if_valid, bus.mem_addr); else passes++;
        tick();
        checks++; if ({bus.if_instr, bus.if_pc, bus.if_valid} !== {16'h0040, 20'h40, 1'b1}) $display("FAIL redirect_target: got %h/%h/%b want 0040/00040/1", bus.if_instr, bus.if_pc, bus.if_valid); else passes++;
    endtask

    task automatic test_wrap;
        mem.delete();
        mem[20'hFFFFF] = 16'h0003;
        do_reset(20'hFFFFF);
        // M[0] has already been consumed as the vector, so it can now hold the immediate.
        mem[20'h0] = 16'hAAAA;
        checks++; if (bus.mem_addr !== 20'hFFFFF) $display("FAIL wrap_vector: got %h want fffff", bus.mem_addr); else passes++;
        tick();
        checks++; if (bus.if_valid !== 1'b0 || bus.mem_addr !== 20'h0) $display("FAIL wrap_bubble: got valid %b addr %h want 0 / 0", bus.if_valid, bus.mem_addr); else passes++;
        tick();
        checks++; if ({bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid, bus.mem_addr} !== {16'h0003, 16'hAAAA, 20'hFFFFF, 1'b1, 20'h1}) $display("FAIL wrap_issue: got %h/%h/%h/%b addr %h want 0003/aaaa/fffff/1 addr 1", bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid, bus.mem_addr); else passes++;
    endtask

    task automatic test_reset_mid;
        mem.delete();
        mem[20'h10] = 16'h1230; mem[20'h11] = 16'h4441; mem[20'h12] = 16'h7777;
        do_reset(20'h10);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++; if ({bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid, bus.mem_addr} !== 73'h0) $display("FAIL reset_mid: got %h/%h/%h/%b addr %h want all 0", bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid, bus.mem_addr); else passes++;
        rst = 1'b0;
        tick();
        checks++; if (bus.mem_addr !== 20'h1) $display("FAIL reset_mid_boot: got %h want 1", bus.mem_addr); else passes++;
    endtask

    // Random programs with random stalls and redirects. The reference model
    // charges each instruction one unstalled cycle per word and issues it on
    // its last word.
    task automatic test_random;
        logic [19:0] base, cur, tgt;
        int          done, len;
        logic [15:0] w, e_instr, e_imm;
        logic [19:0] e_pc;
        logic        e_valid, st, rv;
        for (int r = 0; r < 4; r++) begin
            mem.delete();
            base = (r == 3) ? 20'hFFFE0 : 20'($urandom_range(32'h100, 32'hFFF00));
            for (int i = 0; i < 64; i++) mem[base + 20'(i)] = 16'($urandom);
            do_reset(base);
            cur = base; done = 0;
            e_instr = '0; e_imm = '0; e_pc = '0; e_valid = 1'b0;
            for (int c = 0; c < 250; c++) begin
                st  = ($urandom_range(0, 3) == 0);
                rv  = ($urandom_range(0, 11) == 0);
                tgt = base + 20'($urandom_range(0, 63));
                bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = tgt;
                tick();
                if (rv) begin
                    e_valid = 1'b0; cur = tgt; done = 0;
                end else if (!st) begin
                    w = rd(cur);
                    len = w[0] ? 2 : 1;
                    done++;
                    if (done == len) begin
                        e_instr = w;
                        e_imm   = (len == 2) ? rd(cur + 20'd1) : 16'h0;
                        e_pc    = cur;
                        e_valid = 1'b1;
                        cur     = cur + 20'(len);
                        done    = 0;
                    end else begin
                        e_valid = 1'b0;
                    end
                end
                checks++; if (bus.if_valid !== e_valid) $display("FAIL rand_valid r%0d c%0d: got %b want %b", r, c, bus.if_valid, e_valid); else passes++;
                checks++; if (bus.mem_addr !== cur + 20'(done)) $display("FAIL rand_addr r%0d c%0d: got %h want %h", r, c, bus.mem_addr, cur + 20'(done)); else passes++;
                checks++; if ({bus.if_instr, bus.if_imm, bus.if_pc} !== {e_instr, e_imm, e_pc}) $display("FAIL rand_ifid r%0d c%0d: got %h/%h/%h want %h/%h/%h", r, c, bus.if_instr, bus.if_imm, bus.if_pc, e_instr, e_imm, e_pc); else passes++;
            end
            bus.stall = 1'b0; bus.redirect_valid = 1'b0;
        end
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        #1;
        test_reset();
        test_two_word_and_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the five-stage pipeline. It sits directly downstream of the instruction memory array, which is loaded from `CODE_RAM.mem` at simulation start. After reset it reads the 2-word reset vector at M[0]/M[1], then fetches 1- or 2-word instructions sequentially. It presents each instruction, its immediate and its PC in the IF/ID register, and supports decode-side stall and branch/jump redirect.

## Interface
- `DATA_W`, 16: instruction word width; fixed at 16.
- `ADDR_W`, 20: PC / memory address width; legal range 17..32.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_addr`  out  ADDR_W  instruction memory address; combinationally equal to `pc`.
- `mem_rdata`  in  DATA_W  memory word at `mem_addr`, same cycle (asynchronous read).
- `stall`  in  1  decode cannot accept; hold PC, state and IF/ID outputs.
- `redirect_valid`  in  1  taken branch/jump/interrupt; load `redirect_pc`.
- `redirect_pc`  in  ADDR_W  redirect target.
- `if_instr`  out  DATA_W  IF/ID instruction word.
- `if_imm`  out  DATA_W  IF/ID immediate word; 0 for 1-word instructions.
- `if_pc`  out  ADDR_W  address of the first word of `if_instr`.
- `if_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- Internal registers:
  - `pc` (ADDR_W)
  - `vec_lo` (16)
  - `held` (16)
  - `state` ∈ {BOOT_LO, BOOT_HI, FETCH, IMM}
- Reset (`rst`=1 at an edge):
  - `pc`=0, `state`=BOOT_LO.
  - `if_instr`=0, `if_imm`=0, `if_pc`=0, `if_valid`=0.
  - `vec_lo` and `held` are cleared.
  - Reset mid-operation discards any half-fetched instruction.
- BOOT_LO: `vec_lo`←`mem_rdata`; `pc`←1; → BOOT_HI.
- BOOT_HI: `pc`←{`mem_rdata`[ADDR_W-17:0], `vec_lo`}; → FETCH. Upper bits of M[1] are ignored.
- In both BOOT states:
  - `stall` and `redirect_valid` are ignored.
  - `if_valid` stays 0.
- Word format: `mem_rdata`[0]=1 marks a 2-word instruction (opcode word followed by immediate word). `mem_rdata`[0]=0 marks a 1-word instruction.
- Priority in FETCH and IMM: redirect > stall > normal.
- FETCH:
  - Redirect: `pc`←`redirect_pc`, `if_valid`←0, stay FETCH.
  - Stall: hold everything.
  - Normal, 1-word: `if_instr`←`mem_rdata`, `if_imm`←0, `if_pc`←`pc`, `if_valid`←1, `pc`←`pc`+1.
  - Normal, 2-word: `held`←`mem_rdata`, `if_valid`←0, `pc`←`pc`+1, → IMM.
- IMM:
  - Redirect: `pc`←`redirect_pc`, `if_valid`←0, drop `held`, → FETCH.
  - Stall: hold everything, including `held`.
  - Normal: `if_instr`←`held`, `if_imm`←`mem_rdata`, `if_pc`←`pc`−1, `if_valid`←1, `pc`←`pc`+1, → FETCH.
- Arithmetic:
  - `pc`+1 and `pc`−1 are modulo 2^ADDR_W, so 2^ADDR_W−1 wraps to 0.
  - A 2-word instruction at the last address takes its immediate from address 0 and reports `if_pc`=2^ADDR_W−1.
- Redirect and stall in the same cycle: redirect wins, and the stalled IF/ID contents are replaced by a bubble.

## Timing
- Reset release to first instruction issue: the first normal FETCH is the 3rd edge after `rst` drops, so `if_valid`=1 appears after that edge.
- Throughput and latency:
  - 1-word instruction: 1 per cycle, 1-cycle latency (memory read to IF/ID).
  - 2-word instruction: 2 cycles, with one bubble (`if_valid`=0) during the opcode cycle.
- Redirect: the target instruction's word is read in the cycle after `redirect_valid`. Exactly one bubble is inserted for a 1-word target.
- Stall: outputs are bit-for-bit stable for every stalled cycle; resumes with no loss or duplication.
- `mem_addr` changes only on clock edges.

## Test plan
- Reset vector: M[0]=0x0010, M[1]=0x0000, M[0x10]=0x1234 (1-word). Release `rst` → `mem_addr` 0, 1, 0x10; after 3rd edge `if_instr`=0x1234, `if_pc`=0x10, `if_valid`=1.
- Two-word: M[0x10]=0x2001, M[0x11]=0xBEEF, M[0x12]=0x0002 → bubble, then (`if_instr`=0x2001, `if_imm`=0xBEEF, `if_pc`=0x10), then (0x0002, 0, 0x12).
- Stall: assert `stall` 3 cycles while IF/ID holds 0x0002 and again while in IMM → outputs and `mem_addr` frozen; sequence resumes unchanged, no duplicates.
- Redirect: `redirect_valid`=1, `redirect_pc`=0x40 during IMM, with `stall`=1 simultaneously → `if_valid`=0 next edge, `mem_addr`=0x40, held opcode never issued.
- Wrap: reset vector 0xFFFFF, M[0xFFFFF]=0x0003, M[0]=0xAAAA → `if_instr`=0x0003, `if_imm`=0xAAAA, `if_pc`=0xFFFFF; next `mem_addr`=1.
- Reset mid-fetch: assert `rst` while in IMM → all outputs 0 next edge, `state` BOOT_LO, `mem_addr`=0.
